// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate/control decode,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stop,
  input  logic        flush,
  input  logic [31:0] inst_IFID,
  input  logic [31:0] pc_IFID,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] rs1_data_E,
  output logic [31:0] rs2_data_E,
  output logic [31:0] imm_E,
  output logic [31:0] pc_E,
  output logic [4:0]  rd_E,
  output logic [2:0]  funct3_E,
  output logic [6:0]  op_E,
  output logic [3:0]  alu_op_E,
  output logic        alu_src_E,
  output logic        reg_we_E,
  output logic        mem_read_E,
  output logic        mem_write_E,
  output logic        jump_E,
  output logic        branch_E,
  output logic        bubble
);

  typedef struct packed {
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  op;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_we;
    logic        mem_read;
    logic        mem_write;
    logic        jump;
    logic        branch;
  } id_ex_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BRA   = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [31:0] rf [32];
  logic [31:0] inst;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic        is_load, is_alui, is_auipc, is_store, is_alu;
  logic        is_lui, is_bra, is_jalr, is_jal;
  logic        valid, use_rs1, use_rs2, hazard;
  logic [31:0] imm, rs1_val, rs2_val;
  logic [3:0]  alu_op;
  id_ex_t      d, q, nop;

  assign inst = inst_IFID;
  assign opc  = inst[6:0];
  assign rd   = inst[11:7];
  assign f3   = inst[14:12];
  assign rs1  = inst[19:15];
  assign rs2  = inst[24:20];

  assign is_load  = opc == OP_LOAD;
  assign is_alui  = opc == OP_ALUI;
  assign is_auipc = opc == OP_AUIPC;
  assign is_store = opc == OP_STORE;
  assign is_alu   = opc == OP_ALU;
  assign is_lui   = opc == OP_LUI;
  assign is_bra   = opc == OP_BRA;
  assign is_jalr  = opc == OP_JALR;
  assign is_jal   = opc == OP_JAL;

  assign valid = is_load | is_alui | is_auipc | is_store | is_alu |
                 is_lui | is_bra | is_jalr | is_jal;
  assign use_rs1 = valid & ~(is_lui | is_auipc | is_jal);
  assign use_rs2 = is_alu | is_store | is_bra;

  function automatic logic [3:0] alu_map(input logic alt,
                                         input logic [2:0] fn);
    logic [3:0] r;
    case (fn)
      3'b000:  r = alt ? 4'b1000 : 4'b0000;
      3'b001:  r = 4'b0101;
      3'b010:  r = 4'b1001;
      3'b011:  r = 4'b1010;
      3'b100:  r = 4'b0100;
      3'b101:  r = alt ? 4'b1110 : 4'b0110;
      3'b110:  r = 4'b0010;
      default: r = 4'b0001;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // write-through so a same-cycle writeback is seen by the reader
  always_comb begin
    rs1_val = rf[rs1];
    if (rs1 == 5'd0) rs1_val = '0;
    else if (wb_we && wb_rd == rs1) rs1_val = wb_data;
    rs2_val = rf[rs2];
    if (rs2 == 5'd0) rs2_val = '0;
    else if (wb_we && wb_rd == rs2) rs2_val = wb_data;
  end

  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_load, is_alui, is_jalr:
        imm = {{20{inst[31]}}, inst[31:20]};
      is_store:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      is_bra:
        imm = {{19{inst[31]}}, inst[31], inst[7],
               inst[30:25], inst[11:8], 1'b0};
      is_lui, is_auipc:
        imm = {inst[31:12], 12'd0};
      is_jal:
        imm = {{11{inst[31]}}, inst[31], inst[19:12],
               inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    alu_op = 4'b0000;
    unique case (1'b1)
      is_alu:  alu_op = alu_map(inst[30], f3);
      is_alui: alu_op = alu_map(inst[30] & (f3 == 3'b101), f3);
      is_bra:  alu_op = 4'b1000;
      default: alu_op = 4'b0000;
    endcase
  end

  always_comb begin
    d = '0;
    d.pc = pc_IFID;
    if (valid) begin
      d.rs1_data  = is_lui ? '0 : rs1_val;
      d.rs2_data  = rs2_val;
      d.imm       = imm;
      d.rd        = rd;
      d.funct3    = f3;
      d.op        = opc;
      d.alu_op    = alu_op;
      d.alu_src   = ~(is_alu | is_bra);
      d.reg_we    = ~(is_store | is_bra) & (rd != 5'd0);
      d.mem_read  = is_load;
      d.mem_write = is_store;
      d.jump      = is_jal | is_jalr;
      d.branch    = is_bra;
    end
  end

  always_comb begin
    nop    = '0;
    nop.pc = pc_IFID;
  end

  assign hazard = q.mem_read && q.rd != 5'd0 &&
                  ((use_rs1 && rs1 == q.rd) ||
                   (use_rs2 && rs2 == q.rd));
  assign bubble = hazard && !stop && !flush;

  always_ff @(posedge clk) begin
    if (!rst) q <= '0;
    else if (!stop) q <= (flush || bubble) ? nop : d;
  end

  assign rs1_data_E  = q.rs1_data;
  assign rs2_data_E  = q.rs2_data;
  assign imm_E       = q.imm;
  assign pc_E        = q.pc;
  assign rd_E        = q.rd;
  assign funct3_E    = q.funct3;
  assign op_E        = q.op;
  assign alu_op_E    = q.alu_op;
  assign alu_src_E   = q.alu_src;
  assign reg_we_E    = q.reg_we;
  assign mem_read_E  = q.mem_read;
  assign mem_write_E = q.mem_write;
  assign jump_E      = q.jump;
  assign branch_E    = q.branch;

endmodule
